// File: rtl/dac_pkg.sv
// Shared types and constants for the LTC2624-style DAC writer.
// DAC_ROUND_EN selects round-to-nearest sample conversion instead of truncation.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } dac_state_e;

  localparam int         FRAME_BITS           = 32;
  localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] DAC_ADDR_ALL         = 4'b1111;

  // Signed 20-bit sample to 12-bit offset-binary DAC code.
  function automatic logic [11:0] dac_code(input logic [19:0] vin);
`ifdef DAC_ROUND_EN
    logic signed [20:0] t;
    t = $signed({vin[19], vin}) + 21'sd128;
    if (t > 21'sd524287) begin
      t = 21'sd524287;
    end
    return {~t[19], t[18:8]};
`else
    return {~vin[19], vin[18:8]};
`endif
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator for the SPI clock: one-cycle tick every CLK_DIV
// enabled cycles, restarted by clr.
module spi_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = en && (cnt_q == 8'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_spi_writer.sv
// Captures filtered samples on rising edges of clk_in and shifts each one to a
// serial DAC as a 32-bit SPI frame. DAC_ROUND_EN enables rounding conversion.
module dac_spi_writer
  import dac_pkg::*;
#(
  parameter int         CLK_DIV  = 2,
  parameter logic [3:0] DAC_CMD  = DAC_CMD_WRITE_UPDATE,
  parameter logic [3:0] DAC_ADDR = DAC_ADDR_ALL
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic        clk_in,
  input  logic [19:0] Vin,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        dac_cs_n,
  output logic        dac_clr_n,
  output logic        busy,
  output logic        overrun
);

  localparam int CW = $clog2(FRAME_BITS);

  dac_state_e            state_q, state_d;
  logic                  clk_in_q, clk_in_d;
  logic                  pend_q, pend_d;
  logic [11:0]           pend_code_q, pend_code_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic                  dac_clr_n_q, dac_clr_n_d;

  logic                  strobe;
  logic                  tick;
  logic                  tick_en;
  logic                  frame_start;
  logic [FRAME_BITS-1:0] frame_word;

  assign strobe     = clk_in && !clk_in_q;
  assign tick_en    = (state_q == SHIFT) || (state_q == HOLD);
  assign frame_word = {8'h00, DAC_CMD, DAC_ADDR, pend_code_q, 4'h0};

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (qzt_clk),
    .srst(reset),
    .clr (frame_start),
    .en  (tick_en),
    .tick(tick)
  );

  always_comb begin
    state_d     = state_q;
    clk_in_d    = clk_in;
    pend_d      = pend_q;
    pend_code_d = pend_code_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    dac_clr_n_d = ~reset;
    frame_start = 1'b0;
    // The load in IDLE consumes the old pending sample, so a same-cycle strobe is not an overrun.
    overrun_d   = strobe && pend_q && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          sh_d        = frame_word;
          pend_d      = 1'b0;
          cs_n_d      = 1'b0;
          busy_d      = 1'b1;
          mosi_d      = frame_word[FRAME_BITS-1];
          sck_d       = 1'b0;
          bit_cnt_d   = '0;
          frame_start = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sck_d = ~sck_q;
          // Data only moves on the falling SCK edge so it is stable at the rise.
          if (sck_q) begin
            if (bit_cnt_q == CW'(FRAME_BITS - 1)) begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = HOLD;
            end else begin
              sh_d      = {sh_q[FRAME_BITS-2:0], sh_q[FRAME_BITS-1]};
              mosi_d    = sh_q[FRAME_BITS-2];
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (strobe) begin
      pend_d      = 1'b1;
      pend_code_d = dac_code(Vin);
    end
  end

  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_in_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_in_q    <= clk_in_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
    dac_clr_n_q <= dac_clr_n_d;
  end

  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;
  assign dac_cs_n  = cs_n_q;
  assign dac_clr_n = dac_clr_n_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Directed bench for dac_spi_writer: decodes SPI frames on SCK rise and
// compares against hand-computed frame words.
module tb_dac_spi_writer;

  logic        clk;
  logic        reset;
  logic        clk_in;
  logic [19:0] Vin;
  logic        spi_sck;
  logic        spi_mosi;
  logic        dac_cs_n;
  logic        dac_clr_n;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int frames = 0;
  int ovr_cnt = 0;
  logic cs_prev = 1'b1;

  dac_spi_writer #(.CLK_DIV(2)) dut (
    .qzt_clk  (clk),
    .reset    (reset),
    .clk_in   (clk_in),
    .Vin      (Vin),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .dac_cs_n (dac_cs_n),
    .dac_clr_n(dac_clr_n),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: counts frame starts and overrun pulses.
  always @(negedge clk) begin
    if (dac_cs_n === 1'b0 && cs_prev === 1'b1) frames <= frames + 1;
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    cs_prev <= dac_cs_n;
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [19:0] v);
    Vin = v;
    clk_in = 1'b1;
    @(negedge clk);
    clk_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic capture_frame(output logic [31:0] word, output int nbits,
                               output int low_cycles, output bit ok);
    int t;
    logic prev;
    word = '0; nbits = 0; low_cycles = 0; ok = 1'b0; t = 0;
    while (dac_cs_n === 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (dac_cs_n !== 1'b0) return;
    prev = spi_sck;
    while (dac_cs_n === 1'b0 && low_cycles < 2000) begin
      low_cycles++;
      @(negedge clk);
      if (spi_sck === 1'b1 && prev === 1'b0) begin
        word = {word[30:0], spi_mosi};
        nbits++;
      end
      prev = spi_sck;
    end
    ok = (dac_cs_n === 1'b1);
    $display("frame word=%08h bits=%0d cs_low=%0d", word, nbits, low_cycles);
  endtask

  task automatic wait_idle(output bit ok);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    ok = (busy === 1'b0);
    tick_n(2);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick_n(3);
    total++;
    if ({dac_cs_n, spi_sck, spi_mosi, busy, overrun, dac_clr_n} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_outputs got cs_n,sck,mosi,busy,ovr,clr_n=%b want 100000",
               {dac_cs_n, spi_sck, spi_mosi, busy, overrun, dac_clr_n});
    end
    reset = 1'b0;
    tick_n(1);
    total++;
    if (dac_clr_n !== 1'b1) begin
      bad++;
      $display("FAIL clr_release got %b want 1", dac_clr_n);
    end
  endtask

  task automatic test_basic;
    logic [31:0] w; int nb; int low; bit ok;
    strobe(20'h00000);
    capture_frame(w, nb, low, ok);
    total++;
    if (!ok || w !== 32'h003F8000 || nb != 32) begin
      bad++;
      $display("FAIL basic_word got %08h bits=%0d ok=%0d want 003f8000 bits=32", w, nb, ok);
    end
    total++;
    if (low != 128) begin
      bad++;
      $display("FAIL basic_cs_low got %0d want 128", low);
    end
    total++;
    if (spi_mosi !== 1'b0 || spi_sck !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle_lines got mosi=%b sck=%b want 0 0", spi_mosi, spi_sck);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_hold0 busy got %b want 1", busy);
    end
    tick_n(1);
    total++;
    if (busy !== 1'b1 || dac_cs_n !== 1'b1) begin
      bad++;
      $display("FAIL basic_hold1 busy=%b cs_n=%b want 1 1", busy, dac_cs_n);
    end
    tick_n(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold_end busy got %b want 0", busy);
    end
  endtask

  task automatic test_extremes;
    logic [31:0] w; int nb; int low; bit ok;
    strobe(20'h80000);
    capture_frame(w, nb, low, ok);
    total++;
    if (!ok || w !== 32'h003F0000) begin
      bad++;
      $display("FAIL min_code got %08h want 003f0000", w);
    end
    wait_idle(ok);
    strobe(20'h7FFFF);
    capture_frame(w, nb, low, ok);
    total++;
    if (!ok || w !== 32'h003FFFF0) begin
      bad++;
      $display("FAIL max_code got %08h want 003ffff0", w);
    end
    wait_idle(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL extremes_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_overrun;
    logic [31:0] w1, w2; int nb1, nb2, low1, low2; bit ok1, ok2, oki;
    int f0, o0;
    f0 = frames;
    o0 = ovr_cnt;
    strobe(20'h10000);
    fork
      capture_frame(w1, nb1, low1, ok1);
      begin
        tick_n(12);
        strobe(20'h20000);
        tick_n(3);
        strobe(20'hF0000);
      end
    join
    capture_frame(w2, nb2, low2, ok2);
    wait_idle(oki);
    tick_n(10);
    total++;
    if (!ok1 || w1 !== 32'h003F9000) begin
      bad++;
      $display("FAIL ovr_first got %08h want 003f9000", w1);
    end
    total++;
    if (!ok2 || w2 !== 32'h003F7000) begin
      bad++;
      $display("FAIL ovr_newest got %08h want 003f7000", w2);
    end
    total++;
    if (ovr_cnt - o0 != 1) begin
      bad++;
      $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - o0);
    end
    total++;
    if (frames - f0 != 2) begin
      bad++;
      $display("FAIL ovr_frames got %0d want 2", frames - f0);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] w; int nb; int low; bit ok;
    int t, edges, f0;
    logic prev;
    strobe(20'h00000);
    t = 0;
    while (dac_cs_n !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    edges = 0;
    prev = spi_sck;
    while (edges < 10 && t < 500) begin
      @(negedge clk);
      t++;
      if (spi_sck !== prev) edges++;
      prev = spi_sck;
    end
    total++;
    if (edges != 10) begin
      bad++;
      $display("FAIL mid_edges got %0d want 10", edges);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({dac_cs_n, spi_sck, busy, dac_clr_n} !== 4'b1000) begin
      bad++;
      $display("FAIL mid_reset got cs_n,sck,busy,clr_n=%b want 1000",
               {dac_cs_n, spi_sck, busy, dac_clr_n});
    end
    reset = 1'b0;
    f0 = frames;
    tick_n(200);
    total++;
    if (frames != f0 || dac_cs_n !== 1'b1) begin
      bad++;
      $display("FAIL mid_no_resume got frames=%0d cs_n=%b want 0 1", frames - f0, dac_cs_n);
    end
    strobe(20'h7FFFF);
    capture_frame(w, nb, low, ok);
    total++;
    if (!ok || w !== 32'h003FFFF0 || nb != 32) begin
      bad++;
      $display("FAIL mid_after got %08h bits=%0d want 003ffff0 bits=32", w, nb);
    end
    wait_idle(ok);
  endtask

  task automatic test_held_high;
    int f0;
    bit ok;
    f0 = frames;
    Vin = 20'h12300;
    clk_in = 1'b1;
    tick_n(100);
    Vin = 20'h45600;
    tick_n(100);
    clk_in = 1'b0;
    wait_idle(ok);
    tick_n(20);
    total++;
    if (frames - f0 != 1 || !ok) begin
      bad++;
      $display("FAIL held_high frames got %0d want 1", frames - f0);
    end
  endtask

  task automatic test_round;
    logic [31:0] w; int nb; int low; bit ok;
    logic [31:0] exp_w;
`ifdef DAC_ROUND_EN
    exp_w = 32'h003F8010;
`else
    exp_w = 32'h003F8000;
`endif
    strobe(20'h000FF);
    capture_frame(w, nb, low, ok);
    total++;
    if (!ok || w !== exp_w) begin
      bad++;
      $display("FAIL round_255 got %08h want %08h", w, exp_w);
    end
    wait_idle(ok);
  endtask

  initial begin
    reset  = 1'b1;
    clk_in = 1'b0;
    Vin    = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_overrun();
    test_reset_mid();
    test_held_high();
    test_round();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
